// File: rtl/key_search_dispatcher.sv
// Multi-core key range dispatcher: hands candidate keys to N_CORES decrypt cores,
// gathers their verdicts, latches the first winning key or flags range exhaustion.
module key_search_dispatcher #(
  parameter int              KEY_W     = 24,
  parameter longint unsigned KEY_FIRST = 0,
  parameter longint unsigned KEY_LIMIT = 64'h400000,
  parameter int              N_CORES   = 4,
  parameter int              IDX_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic [N_CORES-1:0]         core_start,
  output logic [N_CORES*KEY_W-1:0]   core_key,
  input  logic [N_CORES-1:0]         core_done,
  input  logic [N_CORES-1:0]         core_success,
  output logic                       busy,
  output logic                       success,
  output logic                       total_failure,
  output logic [KEY_W-1:0]           found_key,
  output logic [IDX_W-1:0]           found_core,
  output logic [KEY_W:0]             keys_tried,
  output logic [9:0]                 LEDR
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] FOUND     = 2'd2;
  localparam logic [1:0] EXHAUSTED = 2'd3;

  // One extra bit so a limit of 2^KEY_W is reachable without wrapping.
  localparam logic [KEY_W:0] FIRST = (KEY_W+1)'(KEY_FIRST);
  localparam logic [KEY_W:0] LIMIT = (KEY_W+1)'(KEY_LIMIT);

  logic [1:0]         state;
  logic [KEY_W:0]     next_key;
  logic [N_CORES-1:0] core_busy;

  logic [N_CORES-1:0] wins;
  logic [N_CORES-1:0] fails;
  logic               any_win;
  logic [IDX_W-1:0]   win_idx;
  logic [KEY_W-1:0]   win_key;
  logic [KEY_W:0]     fail_count;
  logic               dispatch_ok;
  logic               disp_hit;
  logic [N_CORES-1:0] disp_vec;

  always_comb begin
    wins        = '0;
    fails       = '0;
    if (state == RUN) begin
      wins  = core_done & core_busy & core_success;
      fails = core_done & core_busy & ~core_success;
    end
    any_win     = |wins;

    win_idx     = '0;
    win_key     = '0;
    for (int unsigned i = N_CORES; i > 0; i--) begin
      if (wins[i-1]) begin
        win_idx = IDX_W'(i-1);
        win_key = core_key[(i-1)*KEY_W +: KEY_W];
      end
    end

    fail_count  = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (fails[i]) fail_count = fail_count + (KEY_W+1)'(1);
    end

    // A success this cycle halts dispatch immediately, not one cycle later.
    dispatch_ok = (state == RUN) && enable && (next_key < LIMIT) && !any_win;
    disp_hit    = 1'b0;
    disp_vec    = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (dispatch_ok && !core_busy[i] && !disp_hit) begin
        disp_hit    = 1'b1;
        disp_vec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      next_key   <= FIRST;
      core_busy  <= '0;
      core_start <= '0;
      core_key   <= '0;
      found_key  <= '0;
      found_core <= '0;
      keys_tried <= '0;
    end else begin
      core_start <= disp_vec;
      core_busy  <= (core_busy & ~core_done) | disp_vec;
      for (int unsigned i = 0; i < N_CORES; i++) begin
        if (disp_vec[i]) core_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
      end
      if (disp_hit) next_key <= next_key + (KEY_W+1)'(1);
      keys_tried <= keys_tried + fail_count;

      case (state)
        IDLE: if (enable) state <= RUN;
        RUN: begin
          if (any_win) begin
            state      <= FOUND;
            found_key  <= win_key;
            found_core <= win_idx;
          end else if (next_key == LIMIT && core_busy == '0) begin
            state <= EXHAUSTED;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state == RUN);
  assign success       = (state == FOUND);
  assign total_failure = (state == EXHAUSTED);
  assign LEDR          = (state == FOUND)     ? 10'd3 :
                         (state == EXHAUSTED) ? 10'd4 : 10'd0;

endmodule
